uart_tx_fifo: RTL and testbench

Transmit-side buffer between the CPU bus write path and the UART sender. Queues up to DEPTH bytes written by the CPU and hands them to the sender one at a time over the sender's txen/txstatus handshake. Holds each byte stable for the whole frame. Lets software push bursts without polling TX_STATUS per byte.

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/uart_tx_fifo.sv | 89 ++++++++
 tb/tb_uart_tx_fifo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned FIFO_DEPTH  = 16;

    // Transmit FSM encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with separate occupancy counter and sticky overflow flag.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   pop,
    input  logic                   clr_ovf,
    output logic [UART_DATA_W-1:0] rd_data_c,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   ovf_q, ovf_d;
    logic                   do_push, do_pop;

    // Accept/drop decision, pointer and count update; a pop frees the slot a full write needs
    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        if (clr_ovf)            ovf_d = 1'b0;
        if (push && !do_push)   ovf_d = 1'b1;
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == CNT_W'(0));
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data_c = mem_q[rd_ptr_q];
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer feeding the UART sender one byte per txen/txstatus handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   clr_ovf,
    input  logic                   tx_status,
    output logic                   tx_en,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   busy,
    output logic                   overflow
);

    logic [1:0]             state_q, state_d;
    logic                   tx_en_q, tx_en_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   busy_q, busy_d;
    logic                   pop_c;
    logic [UART_DATA_W-1:0] rd_data_c;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (CLK),
        .rst       (reset),
        .push      (wr_en),
        .wr_data   (wr_data),
        .pop       (pop_c),
        .clr_ovf   (clr_ovf),
        .rd_data_c (rd_data_c),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    // Handshake FSM; the byte is latched on the pop and held until the frame completes
    always_comb begin
        state_d   = state_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        pop_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && tx_status) begin
                    state_d   = ST_LOAD;
                    pop_c     = 1'b1;
                    tx_data_d = rd_data_c;
                    tx_en_d   = 1'b1;
                end
            end
            ST_LOAD:      state_d = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (!tx_status) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (tx_status)  state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FSM and output registers
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_en   = tx_en_q;
    assign tx_data = tx_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural sender model.
module tb_uart_tx_fifo;

    logic       CLK = 1'b0;
    logic       reset, wr_en, clr_ovf, tx_status;
    logic [7:0] wr_data;
    logic       tx_en, full, empty, busy, overflow;
    logic [7:0] tx_data;
    logic [4:0] count;

    int         errors = 0;
    int         checks = 0;
    int         txen_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] held = 8'h00;
    bit         sender_en = 1'b0;
    bit         snd_req = 1'b0;
    int         snd_cnt = 0;
    int         frame_len = 120;

    uart_tx_fifo dut (
        .CLK       (CLK),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr_ovf   (clr_ovf),
        .tx_status (tx_status),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 CLK = ~CLK;

    // Output monitor: scoreboard pop on each start pulse, hold check during frames
    always @(negedge CLK) begin
        if (reset === 1'b0) begin
            if (tx_en === 1'b1) begin
                txen_cnt++;
                snd_req = 1'b1;
                checks++;
                if (tx_status !== 1'b1) begin
                    errors++; $display("FAIL txen_while_sender_busy: tx_status=%b required 1", tx_status);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_tx_en: tx_data=%h with empty scoreboard", tx_data);
                end else begin
                    held = exp_q.pop_front();
                    if (tx_data !== held) begin
                        errors++; $display("FAIL tx_data_order: got %h required %h", tx_data, held);
                    end
                end
            end else if (busy === 1'b1) begin
                checks++;
                if (tx_data !== held) begin
                    errors++; $display("FAIL tx_data_hold: got %h required %h", tx_data, held);
                end
            end
        end
    end

    // Sender model: acknowledges a start pulse one cycle later, busy for frame_len cycles
    initial forever begin
        @(posedge CLK); #1;
        if (sender_en) begin
            if (snd_cnt > 0) begin
                snd_cnt--;
                if (snd_cnt == 0) tx_status = 1'b1;
            end else if (snd_req) begin
                snd_req   = 1'b0;
                tx_status = 1'b0;
                snd_cnt   = frame_len;
            end
        end
    end

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < bound) begin
            @(negedge CLK); n++;
        end
        checks++;
        if (n >= bound) begin
            errors++; $display("FAIL %s_drain_timeout: pending=%0d busy=%b required 0/0", name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b1; wr_data = 8'hFF; clr_ovf = 1'b0; tx_status = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++; if (count !== 5'd0)    begin errors++; $display("FAIL rst_count: got %0d required 0", count); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rst_empty: got %b required 1", empty); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL rst_full: got %b required 0", full); end
        checks++; if (tx_en !== 1'b0)    begin errors++; $display("FAIL rst_tx_en: got %b required 0", tx_en); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h required 00", tx_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b required 0", overflow); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        step();
        reset = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_single();
        int base;
        int n;
        base = txen_cnt;
        frame_len = 120; snd_req = 1'b0; snd_cnt = 0; sender_en = 1'b1;
        step();
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
        step();
        wr_en = 1'b0;
        @(negedge CLK);
        checks++; if (count !== 5'd1)    begin errors++; $display("FAIL single_count_k: got %0d required 1", count); end
        checks++; if (tx_en !== 1'b0)    begin errors++; $display("FAIL single_tx_en_k: got %b required 0", tx_en); end
        @(negedge CLK);
        checks++; if (tx_en !== 1'b1)    begin errors++; $display("FAIL single_tx_en_k1: got %b required 1", tx_en); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data_k1: got %h required a5", tx_data); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL single_busy_k1: got %b required 1", busy); end
        checks++; if (count !== 5'd0)    begin errors++; $display("FAIL single_count_k1: got %0d required 0", count); end
        @(negedge CLK);
        checks++; if (tx_en !== 1'b0)    begin errors++; $display("FAIL single_tx_en_k2: got %b required 0", tx_en); end
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(negedge CLK); n++;
        end
        checks++;
        if (n < 120 || n >= 400) begin
            errors++; $display("FAIL single_busy_span: got %0d cycles required 120..399", n);
        end
        checks++; if (empty !== 1'b1)          begin errors++; $display("FAIL single_empty_end: got %b required 1", empty); end
        checks++; if (txen_cnt - base !== 1)   begin errors++; $display("FAIL single_pulses: got %0d required 1", txen_cnt - base); end
    endtask

    task automatic test_burst();
        int base;
        base = txen_cnt;
        for (int i = 1; i <= 16; i++) begin
            step();
            wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
        end
        step();
        wr_en = 1'b0;
        @(negedge CLK);
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL burst_count: got %0d required 15", count); end
        checks++; if (full !== 1'b0)   begin errors++; $display("FAIL burst_full: got %b required 0", full); end
        wait_drain("burst", 16 * 140);
        checks++; if (txen_cnt - base !== 16) begin errors++; $display("FAIL burst_pulses: got %0d required 16", txen_cnt - base); end
        checks++; if (empty !== 1'b1)         begin errors++; $display("FAIL burst_empty_end: got %b required 1", empty); end
    endtask

    task automatic test_overflow();
        int base;
        base = txen_cnt;
        step();
        sender_en = 1'b0; snd_cnt = 0; snd_req = 1'b0; tx_status = 1'b0; frame_len = 4;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
            if (i < 16) exp_q.push_back(8'h30 + 8'(i));
            step();
        end
        wr_en = 1'b0;
        @(negedge CLK);
        checks++; if (count !== 5'd16)   begin errors++; $display("FAIL ovf_count: got %0d required 16", count); end
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL ovf_full: got %b required 1", full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", overflow); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL ovf_busy: got %b required 0", busy); end
        step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        @(negedge CLK);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", overflow); end
        step();
        clr_ovf = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        step();
        clr_ovf = 1'b0; wr_en = 1'b0;
        @(negedge CLK);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b required 1", overflow); end
        checks++; if (count !== 5'd16)   begin errors++; $display("FAIL ovf_count_after_drop: got %0d required 16", count); end
        step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0; snd_req = 1'b0; sender_en = 1'b1; tx_status = 1'b1;
        wait_drain("ovf", 16 * 20);
        checks++; if (txen_cnt - base !== 16) begin errors++; $display("FAIL ovf_pulses: got %0d required 16", txen_cnt - base); end
        checks++; if (overflow !== 1'b0)      begin errors++; $display("FAIL ovf_after_drain: got %b required 0", overflow); end
    endtask

    task automatic test_full_pop();
        step();
        sender_en = 1'b0; snd_cnt = 0; snd_req = 1'b0; tx_status = 1'b0; frame_len = 4;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'h80 + 8'(i); exp_q.push_back(8'h80 + 8'(i));
            step();
        end
        wr_en = 1'b0;
        @(negedge CLK);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fp_full_before: got %b required 1", full); end
        step();
        tx_status = 1'b1; wr_en = 1'b1; wr_data = 8'h77; exp_q.push_back(8'h77);
        snd_req = 1'b0; sender_en = 1'b1;
        step();
        wr_en = 1'b0;
        @(negedge CLK);
        checks++; if (count !== 5'd16)   begin errors++; $display("FAIL fp_count: got %0d required 16", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_overflow: got %b required 0", overflow); end
        checks++; if (tx_en !== 1'b1)    begin errors++; $display("FAIL fp_tx_en: got %b required 1", tx_en); end
        wait_drain("fp", 17 * 20);
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL fp_empty_end: got %b required 1", empty); end
    endtask

    task automatic test_reset_mid();
        int base;
        frame_len = 120;
        for (int i = 0; i < 4; i++) begin
            step();
            wr_en = 1'b1; wr_data = 8'hC0 + 8'(i); exp_q.push_back(8'hC0 + 8'(i));
        end
        step();
        wr_en = 1'b0;
        repeat (10) @(negedge CLK);
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL mid_count_before: got %0d required 3", count); end
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL mid_busy_before: got %b required 1", busy); end
        step();
        reset = 1'b1; sender_en = 1'b0; snd_cnt = 0; snd_req = 1'b0; tx_status = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        checks++; if (count !== 5'd0)    begin errors++; $display("FAIL mid_count: got %0d required 0", count); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy: got %b required 0", busy); end
        checks++; if (tx_en !== 1'b0)    begin errors++; $display("FAIL mid_tx_en: got %b required 0", tx_en); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data: got %h required 00", tx_data); end
        step();
        reset = 1'b0;
        base = txen_cnt;
        repeat (20) @(negedge CLK);
        checks++; if (txen_cnt !== base) begin errors++; $display("FAIL mid_spurious_tx_en: got %0d pulses required 0", txen_cnt - base); end
        frame_len = 4; sender_en = 1'b1;
        step();
        wr_en = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
        step();
        wr_en = 1'b0;
        wait_drain("mid", 50);
        checks++; if (txen_cnt - base !== 1) begin errors++; $display("FAIL mid_new_pulse: got %0d required 1", txen_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover: got %0d bytes required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
